// File: rtl/sipo_load_controller_pkg.sv
// Shared state encoding and default parameters for the SIPO load sequencer.
package sipo_load_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  localparam int DEF_SIZE    = 256;
  localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/sipo_load_controller_sat_up_counter.sv
// Saturating up-counter with synchronous clear (priority) and enable.
module sat_up_counter
  import sipo_load_controller_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                     r_q <= '0;
    else if (i_clr)                r_q <= '0;
    else if (i_en && (r_q != '1))  r_q <= r_q + 1'b1;
  end

  assign o_q = r_q;

endmodule

// File: rtl/sipo_load_controller.sv
// Sequencer for sipo_shift_register: counts SIZE serial bits, then holds the word for a consumer.
// Optional idle watchdog in LOAD enabled by defining SIPO_CTRL_TIMEOUT_EN.
module sipo_load_controller
  import sipo_load_controller_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int CNT_W   = $clog2(SIZE),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic             o_shift,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic [CNT_W-1:0] o_bit_count,
  output logic             o_busy,
  output logic             o_timeout_err
);

  state_e r_state, w_next;
  logic   w_accept, w_last, w_cnt_clr, w_cnt_en, w_tmo;

  assign w_accept = (r_state == ST_LOAD) & i_s_valid & ~i_abort;
  assign w_last   = (o_bit_count == CNT_W'(SIZE - 1));

  sat_up_counter #(.W(CNT_W)) u_bit_cnt (
    .i_clk (i_clk),
    .i_rst (i_reset),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_q   (o_bit_count)
  );

`ifdef SIPO_CTRL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] w_wd;
  logic            r_timeout_err;

  // Cleared outside LOAD so every entry into LOAD starts from zero.
  sat_up_counter #(.W(WD_W)) u_wd_cnt (
    .i_clk (i_clk),
    .i_rst (i_reset),
    .i_clr ((r_state != ST_LOAD) | w_accept),
    .i_en  (1'b1),
    .o_q   (w_wd)
  );

  assign w_tmo = (r_state == ST_LOAD) & ~i_abort & ~w_accept &
                 (w_wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_timeout_err <= 1'b0;
    else         r_timeout_err <= w_tmo;
  end

  assign o_timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_tmo            = 1'b0;
  assign o_timeout_err    = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next    = ST_LOAD;
          w_cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        // abort wins over a simultaneous last bit and over the watchdog
        if (i_abort || w_tmo) begin
          w_next    = ST_IDLE;
          w_cnt_clr = 1'b1;
        end else if (w_accept) begin
          if (w_last) begin
            w_next    = ST_FULL;
            w_cnt_clr = 1'b1;
          end else begin
            w_cnt_en  = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (i_word_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_s_ready    = (r_state == ST_LOAD);
  assign o_shift      = w_accept;
  assign o_word_valid = (r_state == ST_FULL);
  assign o_busy       = (r_state != ST_IDLE);

endmodule
